id_stage: RTL



---
 rtl/mips_pkg.sv | 46 ++++
 rtl/id_stage_if.sv | 13 +
 rtl/reg_file.sv | 43 ++++
 rtl/id_stage.sv | 63 ++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ISA constants, field positions and decode helpers for the 16-bit pipeline
package mips_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 8;

    // Opcodes; 1001-1100 are the branch/store group that reads rt as a source
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_BEQ   = 4'b1001;
    localparam logic [3:0] OP_BNE   = 4'b1010;
    localparam logic [3:0] OP_BLT   = 4'b1011;
    localparam logic [3:0] OP_SW    = 4'b1100;

    localparam logic [DATA_W-1:0] NOP = 16'h0000;

    // Instruction field bit positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 9;
    localparam int RT_MSB  = 8;
    localparam int RT_LSB  = 6;
    localparam int IMM_MSB = 5;

    // Contents of the ID/EX latch
    typedef struct packed {
        logic [DATA_W-1:0] ins;
        logic [DATA_W-1:0] npc;
        logic [DATA_W-1:0] op_1;
        logic [DATA_W-1:0] op_2;
        logic [DATA_W-1:0] imm;
    } id_ex_t;

    // True for opcodes whose rt field is a source operand rather than a destination
    function automatic logic reads_rt(input logic [3:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_BLT)   || (op == OP_SW);
    endfunction

    function automatic logic [DATA_W-1:0] sign_ext6(input logic [IMM_MSB:0] v);
        return {{(DATA_W-IMM_MSB-1){v[IMM_MSB]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - decode-to-execute latch bundle
interface id_stage_if;
    import mips_pkg::*;

    logic [DATA_W-1:0] INS_ID;
    logic [DATA_W-1:0] NPC_ID;
    logic [DATA_W-1:0] op_1;
    logic [DATA_W-1:0] op_2;
    logic [DATA_W-1:0] imm;

    modport master (output INS_ID, NPC_ID, op_1, op_2, imm);
    modport slave  (input  INS_ID, NPC_ID, op_1, op_2, imm);
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8x16 register file, R0 hardwired to zero; ID_WB_BYPASS_EN enables write-before-read
module reg_file
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_ra1,
    input  logic [REG_AW-1:0] i_ra2,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Synchronous clear on reset; writes aimed at R0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Asynchronous read ports; R0 forced to zero, optional same-cycle forwarding of the write
    always_comb begin
        w_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
        w_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];
`ifdef ID_WB_BYPASS_EN
        if (i_we && (i_wa != '0) && (i_wa == i_ra1)) w_rd1 = i_wd;
        if (i_we && (i_wa != '0) && (i_wa == i_ra2)) w_rd2 = i_wd;
`else
`endif
    end

    assign o_rd1 = w_rd1;
    assign o_rd2 = w_rd2;

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage with ID/EX latch, load-use stall and flush; ID_WB_BYPASS_EN selects regfile bypass
module id_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] INS_IF,
    input  logic [DATA_W-1:0] NPC_IF,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] WBA_WB,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              do_branch,
    output logic              stall,
    id_stage_if.master        ex
);

    id_ex_t            r_lat;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [REG_AW-1:0] w_ld_dst;
    logic              w_hazard;

    reg_file u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (INS_IF[RS_MSB:RS_LSB]),
        .i_ra2 (INS_IF[RT_MSB:RT_LSB]),
        .o_rd1 (w_rs_val),
        .o_rd2 (w_rt_val),
        .i_we  (wb_en),
        .i_wa  (WBA_WB),
        .i_wd  (wb_data)
    );

    // A load in the latch writes rt; any consumer of that register in IF must wait one cycle
    assign w_ld_dst = r_lat.ins[RT_MSB:RT_LSB];
    assign w_hazard = (r_lat.ins[OP_MSB:OP_LSB] == OP_LW) && (w_ld_dst != '0) &&
                      ((w_ld_dst == INS_IF[RS_MSB:RS_LSB]) ||
                       ((w_ld_dst == INS_IF[RT_MSB:RT_LSB]) && reads_rt(INS_IF[OP_MSB:OP_LSB])));

    // A flush discards the IF instruction anyway, so it never needs holding
    assign stall = w_hazard && !do_branch;

    // ID/EX latch: reset, flush and stall all insert a zeroed bubble
    always_ff @(posedge clk) begin
        if (rst || do_branch || w_hazard) begin
            r_lat <= '{ins: NOP, npc: '0, op_1: '0, op_2: '0, imm: '0};
        end else begin
            r_lat <= '{ins:  INS_IF,
                       npc:  NPC_IF,
                       op_1: w_rs_val,
                       op_2: w_rt_val,
                       imm:  sign_ext6(INS_IF[IMM_MSB:0])};
        end
    end

    assign ex.INS_ID = r_lat.ins;
    assign ex.NPC_ID = r_lat.npc;
    assign ex.op_1   = r_lat.op_1;
    assign ex.op_2   = r_lat.op_2;
    assign ex.imm    = r_lat.imm;

endmodule
